overlay_mixer: RTL
==================

OVERLAY_MIXER -- requirements
Module: overlay_mixer

Interface
REQ-001 SHALL have parameter hPixels, default 1280, active pixels per line.
REQ-002 SHALL have parameter vPixels, default 720, active lines per frame.
REQ-003 SHALL have parameters hBusWidth / vBusWidth, default 12 / 12, counter widths.
REQ-004 SHALL have parameters ovlWidth / ovlHeight, default 256 / 128, overlay image size in pixels.
REQ-005 SHALL have parameter fifoDepth, default 16, overlay pixel buffer entries (power of two).
REQ-006 SHALL have clock  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have masterReset_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have DE_in, HSYNC_in, VSYNC_in  in  1 each  timing from the sync generator.
REQ-009 SHALL have hCount / vCount  in  hBusWidth / vBusWidth  current pixel position.
REQ-010 SHALL have bgPixel  in  24  background RGB 8:8:8, aligned with hCount.
REQ-011 SHALL have ovlX / ovlY  in  hBusWidth / vBusWidth  overlay origin, sampled at frame start.
REQ-012 SHALL have enable  in  1  overlay on/off, sampled at frame start.
REQ-013 SHALL have ovlData  in  24, ovlValid  in  1, ovlReady  out  1  raster-order overlay stream from the DDR reader.
REQ-014 SHALL have frameStart  out  1  one-cycle pulse telling the DDR reader to restart at image address 0.
REQ-015 SHALL have DE_out, HSYNC_out, VSYNC_out  out  1 each, pixelOut  out  24  mixed video.
REQ-016 SHALL have underflow  out  1  sticky error flag.

Function
REQ-017 SHALL accept an ovlData word on any cycle with ovlValid && ovlReady; ovlReady = FIFO not full && state != IDLE && !frameStart.
REQ-018 SHALL implement states IDLE, RUN, FAULT; reset enters IDLE.
REQ-019 SHALL detect frame start as VSYNC_in rising edge (registered previous value); from any state: pulse frameStart for 1 cycle, flush FIFO, latch ovlX/ovlY/enable, enter RUN.
REQ-020 SHALL clamp latched origin: x = min(ovlX, hPixels-ovlWidth), y = min(ovlY, vPixels-ovlHeight).
REQ-021 SHALL compute inWindow = DE_in && x <= hCount < x+ovlWidth && y <= vCount < y+ovlHeight, compares in hBusWidth+1 / vBusWidth+1 bits (no wrap).
REQ-022 SHALL pop one FIFO entry per inWindow cycle in RUN, regardless of latched enable (keeps stream aligned).
REQ-023 SHALL, on inWindow in RUN with FIFO empty, set underflow, enter FAULT; FAULT pops nothing, outputs background until next frame start.
REQ-024 SHALL output pixelOut = popped overlay pixel when inWindow && enable_latched && pixel != key colour 24'hFF00FF, else bgPixel.
REQ-025 SHALL delay DE, HSYNC, VSYNC and pixelOut by exactly 2 cycles (stage 1: register + window/pop; stage 2: mux).
REQ-026 SHALL force pixelOut = 0 when delayed DE is 0.
REQ-027 SHALL, when push and frame-start coincide, drop the push (ovlReady already 0); flush wins over pop.
REQ-028 SHALL in IDLE output background only and never pop.

Reset
REQ-029 SHALL on masterReset_n=0 at a clock edge clear: state=IDLE, FIFO empty, ovlReady=0, frameStart=0, underflow=0, DE_out/HSYNC_out/VSYNC_out=0, pixelOut=0, latched origin=0, enable_latched=0.
REQ-030 SHALL on reset mid-frame discard pipeline and FIFO contents; resume only at next VSYNC rising edge.

Structure
REQ-031 SHALL place pixel width (24), key colour, and state encoding in shared package hdmi_video_pkg.
REQ-032 SHALL instantiate one sub-module sync_fifo (parameterised width/depth, push/pop/flush, full/empty).

Verification
REQ-033 SHALL cover: reset then VSYNC rise -> frameStart high exactly 1 cycle, state RUN, ovlReady=1 once FIFO not full.
REQ-034 SHALL cover: origin (100,50), stream 0x000001 upward -> pixelOut at hCount=100,vCount=50 equals 0x000001 two cycles later; hCount=99 gives bgPixel.
REQ-035 SHALL cover: overlay word 0xFF00FF in window -> bgPixel output, next word still aligned.
REQ-036 SHALL cover: ovlValid held 0 during window -> underflow=1, background until next VSYNC rise, then RUN.
REQ-037 SHALL cover: ovlX=1200 -> clamped to 1024; last overlay column at hCount=1279.
REQ-038 SHALL cover: masterReset_n low mid-window -> all outputs 0 next cycle, IDLE, FIFO empty.

Source files
------------

// File: rtl/hdmi_video_pkg.sv
// Shared video definitions: pixel format, overlay key colour and mixer state encoding.
package hdmi_video_pkg;

  localparam int PIXEL_W = 24;

  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam pixel_t KEY_COLOUR = 24'hFF00FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } mixer_state_e;

endpackage

// File: rtl/overlay_mixer_if.sv
// Raster-order overlay pixel stream from the DDR reader into the mixer.
interface overlay_mixer_if;
  import hdmi_video_pkg::*;

  pixel_t ovlData;
  logic   ovlValid;
  logic   ovlReady;

  modport master (output ovlData, output ovlValid, input ovlReady);
  modport slave  (input ovlData, input ovlValid, output ovlReady);

endinterface

// File: rtl/overlay_mixer_sync_fifo.sv
// Single-clock FIFO with registered read data; flush takes priority over push and pop.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] data_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        data_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/overlay_mixer.sv
// Mixes a keyed overlay stream over background video inside a clamped window; 2-cycle latency.
module overlay_mixer
  import hdmi_video_pkg::*;
#(
  parameter int hPixels   = 1280,
  parameter int vPixels   = 720,
  parameter int hBusWidth = 12,
  parameter int vBusWidth = 12,
  parameter int ovlWidth  = 256,
  parameter int ovlHeight = 128,
  parameter int fifoDepth = 16
) (
  input  logic                 clock,
  input  logic                 masterReset_n,
  input  logic                 DE_in,
  input  logic                 HSYNC_in,
  input  logic                 VSYNC_in,
  input  logic [hBusWidth-1:0] hCount,
  input  logic [vBusWidth-1:0] vCount,
  input  pixel_t               bgPixel,
  input  logic [hBusWidth-1:0] ovlX,
  input  logic [vBusWidth-1:0] ovlY,
  input  logic                 enable,
  overlay_mixer_if.slave       ovl,
  output logic                 frameStart,
  output logic                 DE_out,
  output logic                 HSYNC_out,
  output logic                 VSYNC_out,
  output pixel_t               pixelOut,
  output logic                 underflow
);
  localparam logic [hBusWidth:0] X_MAX = (hBusWidth+1)'(hPixels - ovlWidth);
  localparam logic [vBusWidth:0] Y_MAX = (vBusWidth+1)'(vPixels - ovlHeight);
  localparam logic [hBusWidth:0] OVL_W = (hBusWidth+1)'(ovlWidth);
  localparam logic [vBusWidth:0] OVL_H = (vBusWidth+1)'(ovlHeight);

  mixer_state_e         state_q;
  logic                 vsync_prev_q, frame_start_q, enable_q, underflow_q;
  logic [hBusWidth-1:0] org_x_q, x_clamp;
  logic [vBusWidth-1:0] org_y_q, y_clamp;
  logic                 de1_q, hs1_q, vs1_q, use_ovl1_q;
  pixel_t               bg1_q;
  logic                 de2_q, hs2_q, vs2_q;
  pixel_t               pix_q, pix_d;

  logic                 frame_rise, in_window, pop_req, underflow_hit;
  logic                 fifo_full, fifo_empty, fifo_push;
  pixel_t               fifo_data;
  logic [hBusWidth:0]   h_ext, x_lo, x_hi;
  logic [vBusWidth:0]   v_ext, y_lo, y_hi;

  assign frame_rise = VSYNC_in && !vsync_prev_q;
  assign x_clamp    = ({1'b0, ovlX} > X_MAX) ? X_MAX[hBusWidth-1:0] : ovlX;
  assign y_clamp    = ({1'b0, ovlY} > Y_MAX) ? Y_MAX[vBusWidth-1:0] : ovlY;

  // One extra bit on every compare so the window end never wraps.
  assign h_ext = {1'b0, hCount};
  assign v_ext = {1'b0, vCount};
  assign x_lo  = {1'b0, org_x_q};
  assign y_lo  = {1'b0, org_y_q};
  assign x_hi  = x_lo + OVL_W;
  assign y_hi  = y_lo + OVL_H;

  assign in_window = DE_in && (h_ext >= x_lo) && (h_ext < x_hi) &&
                     (v_ext >= y_lo) && (v_ext < y_hi);

  // Pops happen even with the overlay disabled so the stream stays raster-aligned.
  assign pop_req       = in_window && (state_q == ST_RUN) && !frame_rise;
  assign underflow_hit = pop_req && fifo_empty;

  assign ovl.ovlReady = !fifo_full && (state_q != ST_IDLE) && !frame_start_q;
  assign fifo_push    = ovl.ovlValid && ovl.ovlReady;

  sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (masterReset_n),
    .push_i  (fifo_push),
    .data_i  (ovl.ovlData),
    .pop_i   (pop_req),
    .flush_i (frame_rise),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    pix_d = bg1_q;
    if (!de1_q) begin
      pix_d = '0;
    end else if (use_ovl1_q && (fifo_data != KEY_COLOUR)) begin
      pix_d = fifo_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!masterReset_n) begin
      state_q       <= ST_IDLE;
      // Held high so a VSYNC already asserted when reset lifts is not taken as a new frame.
      vsync_prev_q  <= 1'b1;
      frame_start_q <= 1'b0;
      enable_q      <= 1'b0;
      underflow_q   <= 1'b0;
      org_x_q       <= '0;
      org_y_q       <= '0;
      de1_q         <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      use_ovl1_q    <= 1'b0;
      bg1_q         <= '0;
      de2_q         <= 1'b0;
      hs2_q         <= 1'b0;
      vs2_q         <= 1'b0;
      pix_q         <= '0;
    end else begin
      vsync_prev_q  <= VSYNC_in;
      frame_start_q <= frame_rise;
      if (frame_rise) begin
        state_q  <= ST_RUN;
        org_x_q  <= x_clamp;
        org_y_q  <= y_clamp;
        enable_q <= enable;
      end else if (underflow_hit) begin
        state_q     <= ST_FAULT;
        underflow_q <= 1'b1;
      end
      de1_q      <= DE_in;
      hs1_q      <= HSYNC_in;
      vs1_q      <= VSYNC_in;
      bg1_q      <= bgPixel;
      use_ovl1_q <= pop_req && !fifo_empty && enable_q;
      de2_q      <= de1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      pix_q      <= pix_d;
    end
  end

  assign frameStart = frame_start_q;
  assign underflow  = underflow_q;
  assign DE_out     = de2_q;
  assign HSYNC_out  = hs2_q;
  assign VSYNC_out  = vs2_q;
  assign pixelOut   = pix_q;

endmodule
